// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: CPU data-side sram-like port to single-beat AXI.
// One transaction in flight; loads use AR/R, stores use AW+W/B.
module sram_axi_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [31:0]       data_rdata,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AWW,
        S_B
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              accept;
    logic              ar_hs;
    logic              r_hs;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              aw_done_q;
    logic              w_done_q;
    logic              aw_fin;
    logic              w_fin;

    logic [1:0]        size_eff;
    logic [3:0]        strb_new;

    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       rdata_q;
    logic              data_ok_q;

    // The CPU only sees acceptance while idle and out of reset.
    assign data_addr_ok = resetn && (state_q == S_IDLE) && data_req;
    assign accept       = data_addr_ok;

    assign arvalid = (state_q == S_AR);
    assign rready  = (state_q == S_R);
    assign awvalid = (state_q == S_AWW) && !aw_done_q;
    assign wvalid  = (state_q == S_AWW) && !w_done_q;
    assign bready  = (state_q == S_B);

    assign ar_hs = arvalid && arready;
    assign r_hs  = rready  && rvalid;
    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid  && wready;
    assign b_hs  = bready  && bvalid;

    // A channel counts as finished once its handshake is seen now or earlier.
    assign aw_fin = aw_done_q || aw_hs;
    assign w_fin  = w_done_q  || w_hs;

    assign araddr = addr_q;
    assign awaddr = addr_q;
    assign arsize = {1'b0, size_q};
    assign awsize = {1'b0, size_q};
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;

    assign data_rdata   = rdata_q;
    assign data_data_ok = data_ok_q;

    // Size 3 folds into a word access; strobes follow the address lane.
    always_comb begin
        size_eff = (data_size == 2'd3) ? 2'd2 : data_size;
        strb_new = 4'b1111;
        unique case (size_eff)
            2'd0:    strb_new = 4'b0001 << data_addr[1:0];
            2'd1:    strb_new = data_addr[1] ? 4'b1100 : 4'b0011;
            default: strb_new = 4'b1111;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection for the single outstanding transaction.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = data_wr ? S_AWW : S_AR;
                end
            end
            S_AR: begin
                if (ar_hs) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (r_hs) begin
                    state_d = S_IDLE;
                end
            end
            S_AWW: begin
                if (aw_fin && w_fin) begin
                    state_d = S_B;
                end
            end
            S_B: begin
                if (b_hs) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the request so later CPU-side changes cannot disturb it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            size_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            addr_q  <= data_addr;
            size_q  <= size_eff;
            wdata_q <= data_wdata;
            wstrb_q <= data_wr ? strb_new : 4'b0000;
        end
    end

    // Track AW and W completion independently during a store.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (accept) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state_q == S_AWW) begin
            if (aw_hs) begin
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                w_done_q <= 1'b1;
            end
        end
    end

    // Hold load data and emit a one-cycle completion pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rdata_q   <= '0;
            data_ok_q <= 1'b0;
        end else begin
            if (r_hs) begin
                rdata_q <= rdata;
            end
            data_ok_q <= r_hs || b_hs;
        end
    end

endmodule
